// File: rtl/operand_issue_stage.sv
// -----------------------------------------------------------------------------
// operand_issue_stage
//
// ID/EX pipeline register sitting directly behind the register file. Each cycle
// it resolves the two source operands (MEM bypass, then WB bypass, then the
// register-file read ports), selects the immediate for operand B when asked,
// and registers operands plus control for the execute stage. A load in EX whose
// destination is read by the decode slot forces a single bubble and holds decode.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_valid / id_ready              decode slot handshake (ready=0 -> decode holds)
//   id_rs, id_rt, id_rd              source/destination addresses
//   id_uses_rs, id_uses_rt           instruction really reads rs / rt
//   id_dataA, id_dataB               register-file read data for rs / rt
//   id_imm, id_use_imm               immediate and operand-B select
//   id_alu_op                        ALU operation
//   id_reg_write/mem_read/mem_write  decoded control bits
//   mem_reg_write, mem_rd, mem_result   MEM-stage bypass source
//   wb_reg_write, wb_rd, wb_data        WB-stage bypass source (register-file write)
//   ex_stall                         hold the EX register
//   flush                            squash decode and EX contents
//   ex_*                             registered operands and control for execute
//   bubble_count                     saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module operand_issue_stage #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int OPW = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           id_valid,
    output logic           id_ready,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic [AW-1:0]  id_rd,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic [DW-1:0]  id_dataA,
    input  logic [DW-1:0]  id_dataB,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_use_imm,
    input  logic [OPW-1:0] id_alu_op,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,

    input  logic           mem_reg_write,
    input  logic [AW-1:0]  mem_rd,
    input  logic [DW-1:0]  mem_result,

    input  logic           wb_reg_write,
    input  logic [AW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,

    input  logic           ex_stall,
    input  logic           flush,

    output logic           ex_valid,
    output logic [DW-1:0]  ex_opA,
    output logic [DW-1:0]  ex_opB,
    output logic [DW-1:0]  ex_store_data,
    output logic [AW-1:0]  ex_rd,
    output logic [OPW-1:0] ex_alu_op,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic [CW-1:0]  bubble_count
);

    // MEM result is younger than WB data, so it wins. The register file only
    // commits at the clock edge, so a same-cycle WB write must be bypassed too.
    // Address 0 is an ordinary register and gets no special treatment.
    function automatic logic [DW-1:0] f_resolve(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rf_data,
        input logic          m_we,
        input logic [AW-1:0] m_rd,
        input logic [DW-1:0] m_data,
        input logic          w_we,
        input logic [AW-1:0] w_rd,
        input logic [DW-1:0] w_dat
    );
        if (m_we && (m_rd == addr))
            return m_data;
        else if (w_we && (w_rd == addr))
            return w_dat;
        else
            return rf_data;
    endfunction

    function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] val);
        if (&val)
            return val;
        else
            return val + 1'b1;
    endfunction

    logic           r_ex_valid;
    logic [DW-1:0]  r_ex_opA;
    logic [DW-1:0]  r_ex_opB;
    logic [DW-1:0]  r_ex_store_data;
    logic [AW-1:0]  r_ex_rd;
    logic [OPW-1:0] r_ex_alu_op;
    logic           r_ex_reg_write;
    logic           r_ex_mem_read;
    logic           r_ex_mem_write;
    logic [CW-1:0]  r_bubble_count;

    logic           w_load_use;
    logic [DW-1:0]  w_rs_val;
    logic [DW-1:0]  w_rt_val;
    logic [DW-1:0]  w_opB;

    // Load data is never available out of EX, so any consumer of an in-flight
    // load must wait one cycle. Only address/control terms feed this.
    assign w_load_use = r_ex_valid && r_ex_mem_read && id_valid &&
                        ((id_uses_rs && (r_ex_rd == id_rs)) ||
                         (id_uses_rt && (r_ex_rd == id_rt)));

    // Flush discards the decode slot, so decode may advance even if a hazard
    // exists; a stall blocks everything.
    assign id_ready = !ex_stall && (flush || !w_load_use);

    assign w_rs_val = f_resolve(id_rs, id_dataA, mem_reg_write, mem_rd, mem_result,
                                wb_reg_write, wb_rd, wb_data);
    assign w_rt_val = f_resolve(id_rt, id_dataB, mem_reg_write, mem_rd, mem_result,
                                wb_reg_write, wb_rd, wb_data);
    assign w_opB    = id_use_imm ? id_imm : w_rt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_opA        <= '0;
            r_ex_opB        <= '0;
            r_ex_store_data <= '0;
            r_ex_rd         <= '0;
            r_ex_alu_op     <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_bubble_count  <= '0;
        end else if (ex_stall) begin
            // Hold everything; a pending flush is re-presented after the stall.
            r_ex_valid <= r_ex_valid;
        end else if (flush || w_load_use) begin
            r_ex_valid      <= 1'b0;
            r_ex_opA        <= '0;
            r_ex_opB        <= '0;
            r_ex_store_data <= '0;
            r_ex_rd         <= '0;
            r_ex_alu_op     <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            if (!flush)
                r_bubble_count <= f_sat_inc(r_bubble_count);
        end else begin
            r_ex_valid      <= id_valid;
            r_ex_opA        <= w_rs_val;
            r_ex_opB        <= w_opB;
            r_ex_store_data <= w_rt_val;
            r_ex_rd         <= id_rd;
            r_ex_alu_op     <= id_alu_op;
            r_ex_reg_write  <= id_reg_write && id_valid;
            r_ex_mem_read   <= id_mem_read  && id_valid;
            r_ex_mem_write  <= id_mem_write && id_valid;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign ex_opA        = r_ex_opA;
    assign ex_opB        = r_ex_opB;
    assign ex_store_data = r_ex_store_data;
    assign ex_rd         = r_ex_rd;
    assign ex_alu_op     = r_ex_alu_op;
    assign ex_reg_write  = r_ex_reg_write;
    assign ex_mem_read   = r_ex_mem_read;
    assign ex_mem_write  = r_ex_mem_write;
    assign bubble_count  = r_bubble_count;

endmodule

// File: tb/tb_operand_issue_stage.sv
module tb_operand_issue_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OPW = 4;
    localparam int CW  = 4;   // small counter so saturation is reachable quickly

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid, id_ready;
    logic [AW-1:0]  id_rs, id_rt, id_rd;
    logic           id_uses_rs, id_uses_rt;
    logic [DW-1:0]  id_dataA, id_dataB, id_imm;
    logic           id_use_imm;
    logic [OPW-1:0] id_alu_op;
    logic           id_reg_write, id_mem_read, id_mem_write;
    logic           mem_reg_write;
    logic [AW-1:0]  mem_rd;
    logic [DW-1:0]  mem_result;
    logic           wb_reg_write;
    logic [AW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;
    logic           ex_stall, flush;
    logic           ex_valid;
    logic [DW-1:0]  ex_opA, ex_opB, ex_store_data;
    logic [AW-1:0]  ex_rd;
    logic [OPW-1:0] ex_alu_op;
    logic           ex_reg_write, ex_mem_read, ex_mem_write;
    logic [CW-1:0]  bubble_count;

    operand_issue_stage #(.DW(DW), .AW(AW), .OPW(OPW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dataA(id_dataA), .id_dataB(id_dataB),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           idv;
        logic [AW-1:0]  rs, rt, rd;
        logic           urs, urt;
        logic [DW-1:0]  da, db, imm;
        logic           uimm;
        logic [OPW-1:0] op;
        logic           rw, mr, mw;
        logic           mrw;
        logic [AW-1:0]  mrd;
        logic [DW-1:0]  mres;
        logic           wrw;
        logic [AW-1:0]  wrd;
        logic [DW-1:0]  wdat;
        logic           stall, fl;
        logic           e_rdy, e_v;
        logic [DW-1:0]  e_a, e_b, e_sd;
        logic [AW-1:0]  e_rd;
        logic [OPW-1:0] e_op;
        logic           e_rw, e_mr, e_mw;
        logic [CW-1:0]  e_bc;
    } vec_t;

    localparam int NV = 13;
    vec_t v [NV];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t dflt();
        vec_t x;
        x = '{default: '0};
        x.e_rdy = 1'b1;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        id_valid = x.idv; id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
        id_uses_rs = x.urs; id_uses_rt = x.urt;
        id_dataA = x.da; id_dataB = x.db; id_imm = x.imm; id_use_imm = x.uimm;
        id_alu_op = x.op; id_reg_write = x.rw; id_mem_read = x.mr; id_mem_write = x.mw;
        mem_reg_write = x.mrw; mem_rd = x.mrd; mem_result = x.mres;
        wb_reg_write = x.wrw; wb_rd = x.wrd; wb_data = x.wdat;
        ex_stall = x.stall; flush = x.fl;
    endtask

    task automatic chk_ex(input string tag, input vec_t x);
        chk({tag, ".ex_valid"},      ex_valid,      x.e_v);
        chk({tag, ".ex_opA"},        ex_opA,        x.e_a);
        chk({tag, ".ex_opB"},        ex_opB,        x.e_b);
        chk({tag, ".ex_store_data"}, ex_store_data, x.e_sd);
        chk({tag, ".ex_rd"},         ex_rd,         x.e_rd);
        chk({tag, ".ex_alu_op"},     ex_alu_op,     x.e_op);
        chk({tag, ".ex_reg_write"},  ex_reg_write,  x.e_rw);
        chk({tag, ".ex_mem_read"},   ex_mem_read,   x.e_mr);
        chk({tag, ".ex_mem_write"},  ex_mem_write,  x.e_mw);
        chk({tag, ".bubble_count"},  bubble_count,  x.e_bc);
    endtask

    initial begin
        vec_t z, ld;
        int   exp_bc;

        // v0: plain add, no bypass
        v[0] = dflt(); v[0].idv = 1; v[0].rs = 1; v[0].rt = 2; v[0].rd = 3; v[0].urs = 1; v[0].urt = 1;
        v[0].da = 32'h5; v[0].db = 32'h6; v[0].op = 4'h2; v[0].rw = 1;
        v[0].e_v = 1; v[0].e_a = 32'h5; v[0].e_b = 32'h6; v[0].e_sd = 32'h6; v[0].e_rd = 3; v[0].e_op = 4'h2; v[0].e_rw = 1;
        // v1: MEM bypass of rd=3 result 0x11 onto rs, immediate on B, rt from RF into store data
        v[1] = dflt(); v[1].idv = 1; v[1].rs = 3; v[1].rt = 4; v[1].rd = 8; v[1].urs = 1;
        v[1].da = 32'h2; v[1].db = 32'h7; v[1].imm = 32'h40; v[1].uimm = 1; v[1].op = 4'h1; v[1].rw = 1;
        v[1].mrw = 1; v[1].mrd = 3; v[1].mres = 32'h11;
        v[1].e_v = 1; v[1].e_a = 32'h11; v[1].e_b = 32'h40; v[1].e_sd = 32'h7; v[1].e_rd = 8; v[1].e_op = 4'h1; v[1].e_rw = 1;
        // v2: MEM and WB both target r5 -> MEM wins
        v[2] = dflt(); v[2].idv = 1; v[2].rs = 5; v[2].rt = 5; v[2].rd = 9; v[2].urs = 1; v[2].urt = 1;
        v[2].da = 32'h1; v[2].db = 32'h1; v[2].rw = 1;
        v[2].mrw = 1; v[2].mrd = 5; v[2].mres = 32'hAA; v[2].wrw = 1; v[2].wrd = 5; v[2].wdat = 32'hBB;
        v[2].e_v = 1; v[2].e_a = 32'hAA; v[2].e_b = 32'hAA; v[2].e_sd = 32'hAA; v[2].e_rd = 9; v[2].e_rw = 1;
        // v3: only WB targets r5 (a store)
        v[3] = dflt(); v[3].idv = 1; v[3].rs = 5; v[3].rt = 5; v[3].rd = 0; v[3].urs = 1; v[3].urt = 1;
        v[3].da = 32'h1; v[3].db = 32'h1; v[3].mw = 1; v[3].op = 4'h6;
        v[3].wrw = 1; v[3].wrd = 5; v[3].wdat = 32'hBB;
        v[3].e_v = 1; v[3].e_a = 32'hBB; v[3].e_b = 32'hBB; v[3].e_sd = 32'hBB; v[3].e_op = 4'h6; v[3].e_mw = 1;
        // v4: r0 is a normal register, WB bypass applies
        v[4] = dflt(); v[4].idv = 1; v[4].rs = 0; v[4].rt = 1; v[4].rd = 2; v[4].urs = 1;
        v[4].da = 32'h0; v[4].db = 32'h3; v[4].rw = 1;
        v[4].wrw = 1; v[4].wrd = 0; v[4].wdat = 32'h9;
        v[4].e_v = 1; v[4].e_a = 32'h9; v[4].e_b = 32'h3; v[4].e_sd = 32'h3; v[4].e_rd = 2; v[4].e_rw = 1;
        // v5: id_valid=0 -> control forced 0, fields still loaded
        v[5] = dflt(); v[5].idv = 0; v[5].rs = 1; v[5].rt = 2; v[5].rd = 2; v[5].urs = 1; v[5].urt = 1;
        v[5].da = 32'h33; v[5].db = 32'h44; v[5].op = 4'h5; v[5].rw = 1; v[5].mr = 1; v[5].mw = 1;
        v[5].e_v = 0; v[5].e_a = 32'h33; v[5].e_b = 32'h44; v[5].e_sd = 32'h44; v[5].e_rd = 2; v[5].e_op = 4'h5;
        // v6: load rd=7
        v[6] = dflt(); v[6].idv = 1; v[6].rs = 1; v[6].rt = 0; v[6].rd = 7; v[6].urs = 1;
        v[6].da = 32'h100; v[6].db = 32'h0; v[6].imm = 32'h4; v[6].uimm = 1; v[6].rw = 1; v[6].mr = 1;
        v[6].e_v = 1; v[6].e_a = 32'h100; v[6].e_b = 32'h4; v[6].e_sd = 32'h0; v[6].e_rd = 7; v[6].e_rw = 1; v[6].e_mr = 1;
        // v7: consumer of r7 via rt -> one bubble, decode held, count 0->1
        v[7] = dflt(); v[7].idv = 1; v[7].rs = 1; v[7].rt = 7; v[7].rd = 10; v[7].urs = 1; v[7].urt = 1;
        v[7].da = 32'h1; v[7].db = 32'hDEAD; v[7].op = 4'h3; v[7].rw = 1;
        v[7].e_rdy = 0; v[7].e_bc = 1;
        // v8: same decode reissues; load data 0x1234 arrives on WB path
        v[8] = v[7]; v[8].wrw = 1; v[8].wrd = 7; v[8].wdat = 32'h1234;
        v[8].e_rdy = 1; v[8].e_v = 1; v[8].e_a = 32'h1; v[8].e_b = 32'h1234; v[8].e_sd = 32'h1234;
        v[8].e_rd = 10; v[8].e_op = 4'h3; v[8].e_rw = 1; v[8].e_bc = 1;
        // v9: stall with flush -> EX holds, decode blocked
        v[9] = dflt(); v[9].idv = 1; v[9].rs = 1; v[9].rd = 11; v[9].urs = 1; v[9].da = 32'h777; v[9].rw = 1;
        v[9].stall = 1; v[9].fl = 1;
        v[9].e_rdy = 0; v[9].e_v = 1; v[9].e_a = 32'h1; v[9].e_b = 32'h1234; v[9].e_sd = 32'h1234;
        v[9].e_rd = 10; v[9].e_op = 4'h3; v[9].e_rw = 1; v[9].e_bc = 1;
        // v10: stall drops, flush still high -> bubble, no count
        v[10] = v[9]; v[10].stall = 0;
        v[10].e_rdy = 1; v[10].e_v = 0; v[10].e_a = 0; v[10].e_b = 0; v[10].e_sd = 0;
        v[10].e_rd = 0; v[10].e_op = 0; v[10].e_rw = 0; v[10].e_bc = 1;
        // v11: load rd=4
        v[11] = dflt(); v[11].idv = 1; v[11].rs = 2; v[11].rd = 4; v[11].urs = 1;
        v[11].da = 32'h8; v[11].imm = 32'h10; v[11].uimm = 1; v[11].rw = 1; v[11].mr = 1;
        v[11].e_v = 1; v[11].e_a = 32'h8; v[11].e_b = 32'h10; v[11].e_rd = 4; v[11].e_rw = 1; v[11].e_mr = 1; v[11].e_bc = 1;
        // v12: id_valid=0 reading r4 -> no hazard, no bubble counted
        v[12] = dflt(); v[12].idv = 0; v[12].rs = 4; v[12].urs = 1; v[12].da = 32'h55; v[12].rw = 1;
        v[12].e_rdy = 1; v[12].e_v = 0; v[12].e_a = 32'h55; v[12].e_bc = 1;

        // Reset state
        z = dflt();
        drive(z);
        rst_n = 1'b0;
        #12;
        chk("reset.id_ready", id_ready, 1'b1);
        chk_ex("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk($sformatf("v%0d.id_ready", i), id_ready, v[i].e_rdy);
            @(posedge clk);
            #1;
            chk_ex($sformatf("v%0d", i), v[i]);
        end

        // Repeated load/load-use pairs drive the counter into saturation
        ld = dflt(); ld.idv = 1; ld.rs = 7; ld.urs = 1; ld.rd = 7; ld.rw = 1; ld.mr = 1;
        exp_bc = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(ld);
            #1;
            chk($sformatf("sat%0d.issue_ready", i), id_ready, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d.load_valid", i), ex_valid, 1'b1);
            @(negedge clk);
            #1;
            chk($sformatf("sat%0d.hazard_ready", i), id_ready, 1'b0);
            @(posedge clk);
            #1;
            if (exp_bc < (1 << CW) - 1) exp_bc++;
            chk($sformatf("sat%0d.bubble_valid", i), ex_valid, 1'b0);
            chk($sformatf("sat%0d.bubble_count", i), bubble_count, exp_bc[CW-1:0]);
        end
        chk("sat.final_count", bubble_count, {CW{1'b1}});

        // Issue one more load so EX is live, then reset between edges
        @(negedge clk);
        drive(ld);
        @(posedge clk);
        #1;
        chk("prerst.ex_valid", ex_valid, 1'b1);
        chk("prerst.ex_reg_write", ex_reg_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.id_ready", id_ready, 1'b1);
        chk_ex("midrst", z);
        #5;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
